i2c_regfile_slave: RTL and testbench

//  I2C responder (target) with an internal register file; the counterpart to i2c_master on the shared bus.
//  Bus transactions work as follows:
//   - A write transaction sets a register pointer, then writes data bytes with auto-increment.
//   - A read transaction returns bytes from the current pointer, also with auto-increment.
//  A host-side port gives local logic direct read/write access to the same registers.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_bus_filter.sv | 69 ++++++
 rtl/i2c_regfile_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_i2c_regfile_slave.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bus event codes and ACK levels.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_ADDR,
      ST_PTR,
      ST_ACK_PTR,
      ST_WDATA,
      ST_ACK_W,
      ST_RDATA,
      ST_MACK,
      ST_WAIT_STOP
   } i2c_state_e;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_START = 2'd1,
      EV_STOP  = 2'd2
   } i2c_event_e;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_filter.sv
// Glitch filter for SCL/SDA plus SCL edge and START/STOP detection.
// A filtered line only changes once all FILTER_LEN samples agree; edges and
// bus events are derived from the filtered values only.
module i2c_bus_filter
   import i2c_pkg::*;
#(
   parameter int FILTER_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_filt_o,
   output logic       scl_rise_o,
   output logic       scl_fall_o,
   output logic [1:0] event_o
);

   logic [FILTER_LEN-1:0] scl_sr_q;
   logic [FILTER_LEN-1:0] sda_sr_q;
   logic                  scl_f_q;
   logic                  sda_f_q;
   logic                  scl_prev_q;
   logic                  sda_prev_q;
   i2c_event_e            ev_d;

   // Sample both lines, update filtered values when the window is unanimous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sr_q   <= '1;
         sda_sr_q   <= '1;
         scl_f_q    <= 1'b1;
         sda_f_q    <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sr_q <= {scl_sr_q[FILTER_LEN-2:0], scl_i};
         sda_sr_q <= {sda_sr_q[FILTER_LEN-2:0], sda_i};
         if (&scl_sr_q) begin
            scl_f_q <= 1'b1;
         end else if (~|scl_sr_q) begin
            scl_f_q <= 1'b0;
         end
         if (&sda_sr_q) begin
            sda_f_q <= 1'b1;
         end else if (~|sda_sr_q) begin
            sda_f_q <= 1'b0;
         end
         scl_prev_q <= scl_f_q;
         sda_prev_q <= sda_f_q;
      end
   end

   // SDA transitions while SCL is steadily high are START/STOP conditions.
   always_comb begin
      ev_d = EV_NONE;
      if (scl_f_q && scl_prev_q && sda_prev_q && !sda_f_q) begin
         ev_d = EV_START;
      end else if (scl_f_q && scl_prev_q && !sda_prev_q && sda_f_q) begin
         ev_d = EV_STOP;
      end
   end

   assign sda_filt_o = sda_f_q;
   assign scl_rise_o = scl_f_q & ~scl_prev_q;
   assign scl_fall_o = ~scl_f_q & scl_prev_q;
   assign event_o    = ev_d;

endmodule

// File: rtl/i2c_regfile_slave.sv
// I2C target with an 8-bit register file, auto-incrementing pointer and a
// direct host port onto the same registers.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | bus free or idle after STOP
//   ADDR        | shifting in address byte + R/W
//   ACK_ADDR    | driving ACK for a matched address
//   PTR         | shifting in register pointer byte
//   ACK_PTR     | driving ACK for the pointer byte
//   WDATA       | shifting in a data byte to write
//   ACK_W       | driving ACK for a written data byte
//   RDATA       | shifting out a register byte
//   MACK        | sampling the controller's ACK/NACK after a read byte
//   WAIT_STOP   | not involved; wait for START or STOP
module i2c_regfile_slave
   import i2c_pkg::*;
#(
   parameter int FILTER_LEN = 4,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl_i,
   output logic                  scl_o,
   output logic                  scl_t,
   input  logic                  sda_i,
   output logic                  sda_o,
   output logic                  sda_t,
   input  logic                  enable,
   input  logic [6:0]            device_address,
   input  logic                  host_we,
   input  logic [REG_ADDR_W-1:0] host_addr,
   input  logic [7:0]            host_wdata,
   output logic [7:0]            host_rdata,
   output logic                  wr_valid,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  bus_active,
   output logic                  bus_addressed,
   output logic                  busy
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] PTR_ONE = 1;

   logic                  sda_f;
   logic                  scl_rise;
   logic                  scl_fall;
   logic [1:0]            bus_ev;

   i2c_state_e            state_q;
   logic [3:0]            bit_cnt_q;
   logic [7:0]            shift_q;
   logic [REG_ADDR_W-1:0] ptr_q;
   logic                  rw_q;
   logic                  ack_on_q;
   logic                  mack_q;
   logic                  sda_q;
   logic                  bus_active_q;
   logic                  bus_addressed_q;
   logic                  wr_valid_q;
   logic [REG_ADDR_W-1:0] wr_addr_q;
   logic [7:0]            wr_data_q;
   logic [7:0]            regs_q [NUM_REGS];

   logic [7:0]            byte_d;
   logic                  i2c_we_d;
   logic                  unused_bits;

   i2c_bus_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_filt_o (sda_f),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .event_o    (bus_ev)
   );

   assign byte_d      = {shift_q[6:0], sda_f};
   assign i2c_we_d    = (bus_ev == EV_NONE) && (state_q == ST_WDATA) &&
                        scl_rise && (bit_cnt_q == 4'd7);
   // MSB of the shifter is consumed before the shift, never read afterwards.
   assign unused_bits = shift_q[7];

   // Bus protocol FSM with shifter, bit counter, pointer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         bit_cnt_q       <= 4'd0;
         shift_q         <= 8'd0;
         ptr_q           <= '0;
         rw_q            <= 1'b0;
         ack_on_q        <= 1'b0;
         mack_q          <= I2C_NACK;
         sda_q           <= 1'b1;
         bus_active_q    <= 1'b0;
         bus_addressed_q <= 1'b0;
         wr_valid_q      <= 1'b0;
         wr_addr_q       <= '0;
         wr_data_q       <= 8'd0;
      end else begin
         wr_valid_q <= 1'b0;
         if (bus_ev == EV_START) begin
            state_q         <= ST_ADDR;
            bit_cnt_q       <= 4'd0;
            ack_on_q        <= 1'b0;
            sda_q           <= 1'b1;
            bus_active_q    <= 1'b1;
            bus_addressed_q <= 1'b0;
         end else if (bus_ev == EV_STOP) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= 4'd0;
            ack_on_q        <= 1'b0;
            sda_q           <= 1'b1;
            bus_active_q    <= 1'b0;
            bus_addressed_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE, ST_WAIT_STOP: begin
                  sda_q <= 1'b1;
               end
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= byte_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q <= 4'd0;
                        rw_q      <= byte_d[0];
                        if (enable && (byte_d[7:1] == device_address)) begin
                           state_q         <= ST_ACK_ADDR;
                           bus_addressed_q <= 1'b1;
                        end else begin
                           state_q <= ST_WAIT_STOP;
                        end
                     end
                  end
               end
               ST_PTR: begin
                  if (scl_rise) begin
                     shift_q   <= byte_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q <= 4'd0;
                        ptr_q     <= byte_d[REG_ADDR_W-1:0];
                        state_q   <= ST_ACK_PTR;
                     end
                  end
               end
               ST_WDATA: begin
                  if (scl_rise) begin
                     shift_q   <= byte_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q  <= 4'd0;
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= ptr_q;
                        wr_data_q  <= byte_d;
                        ptr_q      <= ptr_q + PTR_ONE;
                        state_q    <= ST_ACK_W;
                     end
                  end
               end
               // First falling edge starts the ACK, the second one ends it.
               ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_W: begin
                  if (scl_fall) begin
                     if (!ack_on_q) begin
                        ack_on_q <= 1'b1;
                        sda_q    <= I2C_ACK;
                     end else begin
                        ack_on_q  <= 1'b0;
                        sda_q     <= 1'b1;
                        bit_cnt_q <= 4'd0;
                        if ((state_q == ST_ACK_ADDR) && rw_q) begin
                           shift_q <= regs_q[ptr_q];
                           sda_q   <= regs_q[ptr_q][7];
                           state_q <= ST_RDATA;
                        end else if (state_q == ST_ACK_ADDR) begin
                           state_q <= ST_PTR;
                        end else begin
                           state_q <= ST_WDATA;
                        end
                     end
                  end
               end
               ST_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_q     <= 1'b1;
                        ptr_q     <= ptr_q + PTR_ONE;
                        bit_cnt_q <= 4'd0;
                        state_q   <= ST_MACK;
                     end else if (bit_cnt_q != 4'd0) begin
                        shift_q <= {shift_q[6:0], 1'b0};
                        sda_q   <= shift_q[6];
                     end
                  end
               end
               ST_MACK: begin
                  if (scl_rise) begin
                     mack_q    <= sda_f;
                     bit_cnt_q <= 4'd1;
                  end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
                     bit_cnt_q <= 4'd0;
                     if (mack_q == I2C_ACK) begin
                        shift_q <= regs_q[ptr_q];
                        sda_q   <= regs_q[ptr_q][7];
                        state_q <= ST_RDATA;
                     end else begin
                        state_q <= ST_WAIT_STOP;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  sda_q   <= 1'b1;
               end
            endcase
         end
      end
   end

   // Register file; the I2C write is issued last so it wins an index collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'd0;
         end
      end else begin
         if (host_we) begin
            regs_q[host_addr] <= host_wdata;
         end
         if (i2c_we_d) begin
            regs_q[ptr_q] <= byte_d;
         end
      end
   end

   assign host_rdata    = regs_q[host_addr];
   assign scl_o         = 1'b1;
   assign scl_t         = 1'b1;
   assign sda_o         = sda_q;
   assign sda_t         = sda_q;
   assign wr_valid      = wr_valid_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign bus_active    = bus_active_q;
   assign bus_addressed = bus_addressed_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Bench for i2c_regfile_slave: bit-banged open-drain controller, register
// model with pointer, and a scoreboard on the wr_valid write reports.
module tb_i2c_regfile_slave;

   localparam int Q = 8;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       scl_o, scl_t, sda_o, sda_t;
   logic       enable = 1'b1;
   logic [6:0] device_address = 7'h42;
   logic       host_we = 1'b0;
   logic [3:0] host_addr = 4'd0;
   logic [7:0] host_wdata = 8'd0;
   logic [7:0] host_rdata;
   logic       wr_valid;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       bus_active, bus_addressed, busy;

   int         errors = 0;
   int         checks = 0;
   int         bit_no = -1;
   logic [7:0] m_regs [16];
   int         m_ptr = 0;
   wr_t        exp_wr [$];
   wr_t        mon_e;
   logic [7:0] wbuf [8];

   assign sda_bus = sda_m & sda_o;

   always #5 clk = ~clk;

   i2c_regfile_slave #(
      .FILTER_LEN (4),
      .REG_ADDR_W (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .scl_i          (scl_m),
      .scl_o          (scl_o),
      .scl_t          (scl_t),
      .sda_i          (sda_bus),
      .sda_o          (sda_o),
      .sda_t          (sda_t),
      .enable         (enable),
      .device_address (device_address),
      .host_we        (host_we),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_rdata     (host_rdata),
      .wr_valid       (wr_valid),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .bus_active     (bus_active),
      .bus_addressed  (bus_addressed),
      .busy           (busy)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every wr_valid pulse must match the oldest expected write.
   initial begin
      forever begin
         @(negedge clk);
         if (wr_valid) begin
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: got addr %0d data 0x%02h, expected no write",
                        wr_addr, wr_data);
            end else begin
               mon_e = exp_wr.pop_front();
               if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
                  errors++;
                  $display("FAIL wr_report: got (%0d,0x%02h), expected (%0d,0x%02h)",
                           wr_addr, wr_data, mon_e.a, mon_e.d);
               end
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_x(input logic b, output logic r);
      wait_clk(Q);
      sda_m = b;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      r = sda_bus;
      wait_clk(Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(2 * Q);
      sda_m = 1'b0;
      wait_clk(2 * Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(Q);
      sda_m = 1'b0;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(2 * Q);
      sda_m = 1'b1;
      wait_clk(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_no = i;
         bit_x(b[i], r);
      end
      bit_no = -1;
      bit_x(1'b1, r);
      ack = (r == 1'b0);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_no = i;
         bit_x(1'b1, r);
         b[i] = r;
      end
      bit_no = -1;
      bit_x(nack, r);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      host_addr  = a;
      host_wdata = d;
      host_we    = 1'b1;
      @(negedge clk);
      host_we    = 1'b0;
      m_regs[a]  = d;
   endtask

   task automatic check_reg(input string name, input int idx);
      host_addr = 4'(idx);
      #1;
      check(name, int'(host_rdata), int'(m_regs[idx]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sda_o"}, int'(sda_o), 1);
      check({tag, "_sda_t"}, int'(sda_t), 1);
      check({tag, "_wr_valid"}, int'(wr_valid), 0);
      check({tag, "_bus_active"}, int'(bus_active), 0);
      check({tag, "_bus_addressed"}, int'(bus_addressed), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   // Address, pointer, then n bytes from wbuf; model follows the pointer rules.
   task automatic i2c_write(input logic [6:0] a, input logic [7:0] p, input int n,
                            input logic exp_ack);
      logic ack;
      i2c_start();
      write_byte({a, 1'b0}, ack);
      check("wr_addr_ack", int'(ack), int'(exp_ack));
      check("wr_bus_addressed", int'(bus_addressed), int'(exp_ack));
      if (ack) begin
         write_byte(p, ack);
         check("wr_ptr_ack", int'(ack), 1);
         m_ptr = int'(p[3:0]);
         for (int i = 0; i < n; i++) begin
            exp_wr.push_back('{a: 4'(m_ptr), d: wbuf[i]});
            m_regs[m_ptr] = wbuf[i];
            m_ptr = (m_ptr + 1) % 16;
            write_byte(wbuf[i], ack);
            check("wr_data_ack", int'(ack), 1);
         end
      end
      i2c_stop();
   endtask

   // Optional pointer write, repeated START, then n bytes read (last one NACKed).
   task automatic i2c_read(input logic set_ptr, input logic [7:0] p, input int n);
      logic ack;
      logic [7:0] b;
      i2c_start();
      if (set_ptr) begin
         write_byte({7'h42, 1'b0}, ack);
         check("rd_wraddr_ack", int'(ack), 1);
         write_byte(p, ack);
         check("rd_ptr_ack", int'(ack), 1);
         m_ptr = int'(p[3:0]);
         i2c_start();
      end
      write_byte({7'h42, 1'b1}, ack);
      check("rd_addr_ack", int'(ack), 1);
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, b);
         check("rd_data", int'(b), int'(m_regs[m_ptr]));
         m_ptr = (m_ptr + 1) % 16;
      end
      i2c_stop();
   endtask

   initial begin
      logic       ack;
      logic [7:0] b;
      logic       hit;
      logic       seen_busy;
      int         n;
      int         idx;

      for (int i = 0; i < 16; i++) begin
         m_regs[i] = 8'd0;
      end

      // Reset values, during and after reset
      wait_clk(3);
      check_reset_outputs("in_reset");
      rst = 1'b0;
      wait_clk(10);
      check_reset_outputs("after_reset");
      check("scl_o_tied", int'(scl_o), 1);
      check("scl_t_tied", int'(scl_t), 1);
      check_reg("reset_reg0", 0);

      // 1. pointer + two data bytes
      wbuf[0] = 8'hA5;
      wbuf[1] = 8'h5A;
      i2c_write(7'h42, 8'h03, 2, 1'b1);
      check_reg("t1_reg3", 3);
      check_reg("t1_reg4", 4);
      wait_clk(20);
      check("t1_idle_busy", int'(busy), 0);
      check("t1_idle_bus_active", int'(bus_active), 0);

      // 2. write with wrap, then pointer-then-read with wrap
      wbuf[0] = 8'hE1;
      wbuf[1] = 8'h1E;
      i2c_write(7'h42, 8'hFF, 2, 1'b1);
      i2c_read(1'b1, 8'h0F, 2);
      check("t2_ptr_wrapped", m_ptr, 1);

      // 3. address miss and disabled target
      wbuf[0] = 8'hCC;
      i2c_write(7'h43, 8'h02, 1, 1'b0);
      enable = 1'b0;
      i2c_write(7'h42, 8'h02, 1, 1'b0);
      enable = 1'b1;
      check_reg("t3_reg2", 2);

      // 4. host write colliding with an I2C write to index 5
      i2c_start();
      write_byte({7'h42, 1'b0}, ack);
      check("t4_addr_ack", int'(ack), 1);
      write_byte(8'h05, ack);
      check("t4_ptr_ack", int'(ack), 1);
      exp_wr.push_back('{a: 4'd5, d: 8'h77});
      m_regs[5] = 8'h77;
      m_ptr = 6;
      hit = 1'b0;
      fork
         write_byte(8'h77, ack);
         begin
            for (int c = 0; c < 2000; c++) begin
               @(posedge clk);
               #1;
               if (!host_we && bit_no == 0 && scl_m) begin
                  host_addr  = 4'd5;
                  host_wdata = 8'h11;
                  host_we    = 1'b1;
               end else if (host_we && wr_valid) begin
                  host_we = 1'b0;
                  hit = 1'b1;
                  break;
               end
            end
            host_we = 1'b0;
         end
      join
      check("t4_data_ack", int'(ack), 1);
      check("t4_overlap_seen", int'(hit), 1);
      i2c_stop();
      check_reg("t4_reg5", 5);
      host_write(4'd9, 8'h99);
      check_reg("t4_other_host_write", 9);

      // Randomized writes, host writes and reads against the model
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            wbuf[i] = 8'($urandom_range(0, 255));
         end
         i2c_write(7'h42, 8'($urandom_range(0, 255)), n, 1'b1);
         idx = $urandom_range(0, 15);
         host_write(4'(idx), 8'($urandom_range(0, 255)));
         n = $urandom_range(1, 4);
         i2c_read(1'b1, 8'($urandom_range(0, 255)), n);
      end
      // Read continuing from the pointer left by the previous read
      i2c_read(1'b0, 8'h00, 2);

      for (int i = 0; i < 16; i++) begin
         check_reg("sweep_reg", i);
      end

      // 6. 2-clk SDA glitch while SCL is high
      wait_clk(10);
      seen_busy = 1'b0;
      sda_m = 1'b0;
      wait_clk(2);
      sda_m = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (busy || bus_active) seen_busy = 1'b1;
      end
      check("t6_glitch_ignored", int'(seen_busy), 0);

      // 5. reset asserted during bit 3 of a read byte
      host_write(4'd0, 8'hC3);
      i2c_start();
      write_byte({7'h42, 1'b0}, ack);
      check("t5_addr_ack", int'(ack), 1);
      write_byte(8'h00, ack);
      check("t5_ptr_ack", int'(ack), 1);
      i2c_start();
      write_byte({7'h42, 1'b1}, ack);
      check("t5_rd_addr_ack", int'(ack), 1);
      hit = 1'b0;
      fork
         read_byte(1'b1, b);
         begin
            for (int c = 0; c < 4000; c++) begin
               @(negedge clk);
               if (bit_no == 3 && scl_m) begin
                  hit = 1'b1;
                  break;
               end
            end
            check("t5_reached_bit3", int'(hit), 1);
            check("t5_bit3_driven_low", int'(sda_o), 0);
            #2;
            rst = 1'b1;
            #1;
            check_reset_outputs("t5_mid_reset");
            host_addr = 4'd0;
            #1;
            check("t5_regs_cleared", int'(host_rdata), 0);
         end
      join
      i2c_stop();
      wait_clk(4);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_regs[i] = 8'd0;
      end
      m_ptr = 0;
      wait_clk(10);
      i2c_read(1'b0, 8'h00, 1);

      wait_clk(20);
      check("scoreboard_drained", exp_wr.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
